// File: rtl/rx_iq_frame_buffer.sv
// Frame FIFO between the DDC sample strobe and the MCU byte-serial reader.
// Frames are pushed whole on iq_valid and served one byte at a time in bus order.
module rx_iq_frame_buffer #(
    parameter int DEPTH_LOG2 = 3,
    parameter int THRESH     = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  iq_valid,
    input  logic [31:0]           RX1_I,
    input  logic [31:0]           RX1_Q,
    input  logic [31:0]           RX2_I,
    input  logic [31:0]           RX2_Q,
    input  logic                  rx2_en,
    input  logic                  rd_start,
    input  logic                  rd_next,
    input  logic                  ovf_clr,
    output logic [7:0]            byte_out,
    output logic                  byte_valid,
    output logic                  frame_done,
    output logic                  underflow,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  rdy_irq,
    output logic [7:0]            ovf_cnt
);

    // state | meaning
    // IDLE  | no frame being served; waiting for rd_start
    // SEND  | head frame being served, r_idx is the byte on byte_out
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEND = 1'b1;

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam int                  LVL_W     = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0]    FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]    THR_LVL   = LVL_W'(THRESH);

    logic [127:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]        r_level;
    logic                    r_state;
    logic [3:0]              r_idx;
    logic [3:0]              r_idx_last;
    logic [7:0]              r_byte_out;
    logic                    r_byte_valid;
    logic                    r_frame_done;
    logic                    r_underflow;
    logic                    r_rdy_irq;
    logic [7:0]              r_ovf_cnt;

    logic [127:0]            w_head;
    logic [7:0]              w_bytes [16];
    logic [3:0]              w_idx_nxt;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_start_ok;
    logic                    w_start_uf;
    logic                    w_advance;
    logic                    w_last;
    logic                    w_push;
    logic                    w_drop;

    assign w_head = r_mem[r_rd_ptr];

    // Byte 0 is the MSB of RX1_Q; bytes run MSB-first through Q1, I1, Q2, I2.
    for (genvar g = 0; g < 16; g++) begin : g_bytes
        assign w_bytes[g] = w_head[127 - 8*g -: 8];
    end

    assign w_idx_nxt  = r_idx + 4'd1;
    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == FULL_LVL);
    assign w_start_ok = rd_start && !w_empty;
    assign w_start_uf = rd_start && w_empty;
    assign w_advance  = (r_state == ST_SEND) && !rd_start && rd_next;
    assign w_last     = w_advance && (r_idx == r_idx_last);
    // The popped slot is free in the same cycle, so a push into a full FIFO then is accepted.
    assign w_push     = iq_valid && (!w_full || w_last);
    assign w_drop     = iq_valid && w_full && !w_last;

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {RX1_Q, RX1_I, RX2_Q, RX2_I};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_last) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_last) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_last) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_idx_last   <= 4'd7;
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_frame_done <= w_last;
            if (w_start_ok) begin
                // Restart (or abort) always re-serves the head frame from byte 0.
                r_state      <= ST_SEND;
                r_idx        <= '0;
                r_idx_last   <= rx2_en ? 4'd15 : 4'd7;
                r_byte_out   <= w_bytes[0];
                r_byte_valid <= 1'b1;
                r_underflow  <= 1'b0;
            end else if (w_start_uf) begin
                r_byte_out   <= '0;
                r_byte_valid <= 1'b0;
                r_underflow  <= 1'b1;
            end else if (w_last) begin
                r_state      <= ST_IDLE;
                r_idx        <= '0;
                r_byte_out   <= '0;
                r_byte_valid <= 1'b0;
            end else if (w_advance) begin
                r_idx        <= w_idx_nxt;
                r_byte_out   <= w_bytes[w_idx_nxt];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt <= '0;
            r_rdy_irq <= 1'b0;
        end else begin
            r_rdy_irq <= (r_level >= THR_LVL);
            if (ovf_clr) begin
                r_ovf_cnt <= '0;
            end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
        end
    end

    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;
    assign frame_done = r_frame_done;
    assign underflow  = r_underflow;
    assign level      = r_level;
    assign rdy_irq    = r_rdy_irq;
    assign ovf_cnt    = r_ovf_cnt;

endmodule

// File: tb/tb_rx_iq_frame_buffer.sv
// Directed bench for rx_iq_frame_buffer: byte order, overflow, threshold,
// underflow, pop/push collision, abort and mid-frame reset.
module tb_rx_iq_frame_buffer;

    logic        clk_in;
    logic        rst_n;
    logic        iq_valid;
    logic [31:0] RX1_I, RX1_Q, RX2_I, RX2_Q;
    logic        rx2_en;
    logic        rd_start;
    logic        rd_next;
    logic        ovf_clr;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        frame_done;
    logic        underflow;
    logic [3:0]  level;
    logic        rdy_irq;
    logic [7:0]  ovf_cnt;

    int n_total = 0;
    int n_bad   = 0;

    rx_iq_frame_buffer #(.DEPTH_LOG2(3), .THRESH(4)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .iq_valid   (iq_valid),
        .RX1_I      (RX1_I),
        .RX1_Q      (RX1_Q),
        .RX2_I      (RX2_I),
        .RX2_Q      (RX2_Q),
        .rx2_en     (rx2_en),
        .rd_start   (rd_start),
        .rd_next    (rd_next),
        .ovf_clr    (ovf_clr),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .frame_done (frame_done),
        .underflow  (underflow),
        .level      (level),
        .rdy_irq    (rdy_irq),
        .ovf_cnt    (ovf_cnt)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [127:0] frame_of(input int n);
        logic [31:0] step;
        step = 32'(n) * 32'h10101010;
        return {32'h01020304 + step, 32'h05060708 + step,
                32'h090A0B0C + step, 32'h0D0E0F00 + step};
    endfunction

    function automatic logic [7:0] byte_of(input logic [127:0] fr, input int k);
        logic [127:0] t;
        t = fr >> (8 * (15 - k));
        return t[7:0];
    endfunction

    task automatic push(input logic [127:0] fr);
        {RX1_Q, RX1_I, RX2_Q, RX2_I} = fr;
        iq_valid = 1'b1;
        tick();
        iq_valid = 1'b0;
    endtask

    task automatic do_reset();
        iq_valid = 0; rd_start = 0; rd_next = 0; ovf_clr = 0;
        @(negedge clk_in);
        rst_n = 1'b0;
        #3;
        @(negedge clk_in);
        rst_n = 1'b1;
        tick();
    endtask

    // Serves one frame completely, checking every byte and the closing pulse.
    task automatic read_frame(input logic [127:0] fr, input int len, input bit toggle);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        if (toggle) rx2_en = ~rx2_en;
        chk("rd_b0", {24'd0, byte_out}, {24'd0, byte_of(fr, 0)});
        chk("rd_v0", {31'd0, byte_valid}, 32'd1);
        for (int k = 1; k < len; k++) begin
            rd_next = 1'b1;
            tick();
            rd_next = 1'b0;
            chk($sformatf("rd_b%0d", k), {24'd0, byte_out}, {24'd0, byte_of(fr, k)});
            chk("rd_nodone", {31'd0, frame_done}, 32'd0);
        end
        rd_next = 1'b1;
        tick();
        rd_next = 1'b0;
        chk("rd_done", {31'd0, frame_done}, 32'd1);
        chk("rd_vend", {31'd0, byte_valid}, 32'd0);
    endtask

    initial begin
        logic [127:0] f;
        rst_n = 1'b0;
        iq_valid = 0; rd_start = 0; rd_next = 0; ovf_clr = 0; rx2_en = 0;
        RX1_I = 0; RX1_Q = 0; RX2_I = 0; RX2_Q = 0;
        #12;
        chk("rst_level", {28'd0, level}, 32'd0);
        chk("rst_valid", {31'd0, byte_valid}, 32'd0);
        chk("rst_bout", {24'd0, byte_out}, 32'd0);
        chk("rst_ovf", {24'd0, ovf_cnt}, 32'd0);
        chk("rst_irq", {31'd0, rdy_irq}, 32'd0);
        chk("rst_uf", {31'd0, underflow}, 32'd0);
        do_reset();

        // 8-byte frame
        rx2_en = 1'b0;
        f = {32'h11223344, 32'h55667788, 64'd0};
        push(f);
        chk("t1_lvl1", {28'd0, level}, 32'd1);
        read_frame(f, 8, 1'b0);
        chk("t1_lvl0", {28'd0, level}, 32'd0);
        tick();
        chk("t1_donepulse", {31'd0, frame_done}, 32'd0);

        // 16-byte frame, rx2_en dropped mid-frame
        rx2_en = 1'b1;
        f = {32'h11223344, 32'h55667788, 32'hA0B0C0D0, 32'hE0F00102};
        push(f);
        read_frame(f, 16, 1'b1);
        chk("t2_lvl0", {28'd0, level}, 32'd0);

        // overflow: 10 writes into 8 slots
        for (int n = 0; n < 10; n++) push(frame_of(n));
        chk("t3_lvl8", {28'd0, level}, 32'd8);
        chk("t3_ovf2", {24'd0, ovf_cnt}, 32'd2);
        rx2_en = 1'b1;
        for (int n = 0; n < 8; n++) read_frame(frame_of(n), 16, 1'b0);
        chk("t3_drained", {28'd0, level}, 32'd0);
        chk("t3_ovf_keep", {24'd0, ovf_cnt}, 32'd2);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("t3_ovf_clr", {24'd0, ovf_cnt}, 32'd0);
        for (int n = 0; n < 8; n++) push(frame_of(n));
        {RX1_Q, RX1_I, RX2_Q, RX2_I} = frame_of(0);
        iq_valid = 1'b1;
        for (int n = 0; n < 300; n++) tick();
        iq_valid = 1'b0;
        chk("t3_ovf_sat", {24'd0, ovf_cnt}, 32'd255);
        iq_valid = 1'b1; ovf_clr = 1'b1; tick(); iq_valid = 1'b0; ovf_clr = 1'b0;
        chk("t3_clr_wins", {24'd0, ovf_cnt}, 32'd0);
        do_reset();

        // threshold
        rx2_en = 1'b0;
        for (int n = 0; n < 3; n++) push(frame_of(n));
        tick();
        chk("t4_irq_3", {31'd0, rdy_irq}, 32'd0);
        push(frame_of(3));
        chk("t4_irq_lag", {31'd0, rdy_irq}, 32'd0);
        tick();
        chk("t4_irq_4", {31'd0, rdy_irq}, 32'd1);
        read_frame(frame_of(0), 8, 1'b0);
        chk("t4_lvl3", {28'd0, level}, 32'd3);
        chk("t4_irq_lag2", {31'd0, rdy_irq}, 32'd1);
        tick();
        chk("t4_irq_off", {31'd0, rdy_irq}, 32'd0);
        do_reset();

        // underflow
        rd_start = 1'b1; tick(); rd_start = 1'b0;
        chk("t5_uf", {31'd0, underflow}, 32'd1);
        chk("t5_uf_v", {31'd0, byte_valid}, 32'd0);
        rd_next = 1'b1; tick(); rd_next = 1'b0;
        chk("t5_next_idle", {31'd0, byte_valid}, 32'd0);
        push(frame_of(5));
        chk("t5_uf_sticky", {31'd0, underflow}, 32'd1);
        rd_start = 1'b1; tick(); rd_start = 1'b0;
        chk("t5_uf_clr", {31'd0, underflow}, 32'd0);
        chk("t5_b0", {24'd0, byte_out}, {24'd0, byte_of(frame_of(5), 0)});
        chk("t5_v", {31'd0, byte_valid}, 32'd1);
        do_reset();

        // push on the pop cycle of a full FIFO, abort, mid-frame reset
        rx2_en = 1'b0;
        for (int n = 0; n < 8; n++) push(frame_of(n));
        rd_start = 1'b1; tick(); rd_start = 1'b0;
        for (int k = 1; k < 8; k++) begin
            rd_next = 1'b1; tick(); rd_next = 1'b0;
        end
        chk("t6_b7", {24'd0, byte_out}, {24'd0, byte_of(frame_of(0), 7)});
        {RX1_Q, RX1_I, RX2_Q, RX2_I} = frame_of(9);
        iq_valid = 1'b1; rd_next = 1'b1;
        tick();
        iq_valid = 1'b0; rd_next = 1'b0;
        chk("t6_done", {31'd0, frame_done}, 32'd1);
        chk("t6_lvl8", {28'd0, level}, 32'd8);
        chk("t6_ovf0", {24'd0, ovf_cnt}, 32'd0);
        rd_start = 1'b1; tick(); rd_start = 1'b0;
        chk("t6_f1b0", {24'd0, byte_out}, {24'd0, byte_of(frame_of(1), 0)});
        for (int k = 1; k < 4; k++) begin
            rd_next = 1'b1; tick(); rd_next = 1'b0;
        end
        chk("t6_f1b3", {24'd0, byte_out}, {24'd0, byte_of(frame_of(1), 3)});
        rd_start = 1'b1; rd_next = 1'b1; tick(); rd_start = 1'b0; rd_next = 1'b0;
        chk("t6_abort_b0", {24'd0, byte_out}, {24'd0, byte_of(frame_of(1), 0)});
        chk("t6_abort_lvl", {28'd0, level}, 32'd8);
        rd_next = 1'b1; tick(); rd_next = 1'b0;
        chk("t6_abort_b1", {24'd0, byte_out}, {24'd0, byte_of(frame_of(1), 1)});
        @(negedge clk_in);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_lvl", {28'd0, level}, 32'd0);
        chk("t6_rst_v", {31'd0, byte_valid}, 32'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        tick();
        rd_start = 1'b1; tick(); rd_start = 1'b0;
        chk("t6_rst_empty", {31'd0, underflow}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_iq_frame_buffer.md
Name: rx_iq_frame_buffer

Overview:
- Decouples DDC output sample rate from the MCU's byte-serial bus reads.
- Captures each RX1/RX2 IQ sample set on iq_valid into a frame FIFO.
- Serves frames byte-by-byte to the bus-interface FSM (RX IQ command) in bus order.
- Raises a ready request to the MCU at a programmable fill level and counts dropped samples.

Parameters:
- DEPTH_LOG2, 3: FIFO holds 2^DEPTH_LOG2 frames (default 8).
- THRESH, 4: rdy_irq asserts when level >= THRESH; legal range 1..2^DEPTH_LOG2.

Ports:
- clk_in  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- iq_valid  in  1  one-cycle strobe, clk_in-synchronous; RX1_I..RX2_Q valid in the same cycle.
- RX1_I, RX1_Q, RX2_I, RX2_Q  in  32 each  signed DDC outputs.
- rx2_en  in  1  1 = 16-byte frames (RX1+RX2); 0 = 8-byte frames (RX1 only).
- rd_start  in  1  pulse: begin serving head frame from byte 0.
- rd_next  in  1  pulse: current byte consumed, advance.
- ovf_clr  in  1  pulse: clear ovf_cnt.
- byte_out  out  8  current byte for DATA_BUS.
- byte_valid  out  1  byte_out holds frame data.
- frame_done  out  1  one-cycle pulse when the last byte is consumed and the head frame is popped.
- underflow  out  1  sticky; set by rd_start on empty FIFO, cleared by next accepted rd_start.
- level  out  DEPTH_LOG2+1  frames stored.
- rdy_irq  out  1  registered (level >= THRESH).
- ovf_cnt  out  8  dropped-frame count, saturates at 255.

Behaviour:
- Reset values: byte_out=0, byte_valid=0, frame_done=0, underflow=0, level=0, rdy_irq=0, ovf_cnt=0, FSM=IDLE, pointers=0.
- Storage: 128-bit frames {RX1_Q, RX1_I, RX2_Q, RX2_I}; circular wr/rd pointers; pointers wrap at 2^DEPTH_LOG2.
- Write:
  - iq_valid with level < 2^DEPTH_LOG2: store frame, level+1.
  - iq_valid when full: drop the new frame (old data kept), ovf_cnt+1 unless already 255.
  - ovf_clr and a drop in the same cycle: ovf_cnt becomes 0 (clear wins).
- Byte order: index 0..7 = Q1[31:24], Q1[23:16], Q1[15:8], Q1[7:0], I1[31:24] .. I1[7:0]; index 8..15 = the same order for Q2 then I2.
- Frame length: LEN = rx2_en ? 16 : 8, latched at rd_start; changes to rx2_en mid-frame are ignored.
- FSM states:
  - IDLE
    - rd_start with level>0: latch LEN, idx=0, go SEND.
    - rd_start with level==0: underflow=1, byte_out=0, byte_valid=0, stay IDLE.
  - SEND
    - byte_out = head[idx], registered; valid the cycle after rd_start or rd_next (1-cycle latency). byte_valid=1.
    - rd_next with idx<LEN-1: idx+1.
    - rd_next with idx==LEN-1: pop head, level-1, frame_done pulse, byte_valid=0, go IDLE.
    - rd_start in SEND: abort; head is not popped; idx=0; re-serve the same frame.
  - rd_start and rd_next in the same cycle: rd_start wins.
  - rd_next in IDLE: ignored.
- Simultaneous push and pop: level unchanged; a push into a full FIFO in the pop cycle is accepted (the slot frees that cycle), no overflow.
- Head frame is stable during SEND; writes never touch the slot being read.
- rdy_irq tracks level with 1-cycle register delay.
- rst_n assertion mid-frame: immediate return to reset values; all FIFO content discarded.

Test Plan:
- Reset, then 1 iq_valid with RX1_Q=0x11223344, RX1_I=0x55667788, RX2_*=0, rx2_en=0; rd_start + 7x rd_next -> bytes 11,22,33,44,55,66,77,88; frame_done on the 8th consume; level 1->0.
- rx2_en=1, RX2_Q=0xA0B0C0D0, RX2_I=0xE0F00102 -> bytes 9..16 = A0,B0,C0,D0,E0,F0,01,02; rx2_en toggled mid-frame has no effect.
- 10 iq_valid strobes with DEPTH_LOG2=3 and no reads -> level=8, ovf_cnt=2, first 8 frames read back intact; ovf_clr -> ovf_cnt=0; 300 drops -> ovf_cnt saturates at 255.
- THRESH=4: 3 writes -> rdy_irq=0; 4th write -> rdy_irq=1 one cycle later; one frame popped -> rdy_irq=0.
- rd_start on empty FIFO -> underflow=1, byte_valid=0; write a frame, rd_start -> underflow=0, first byte served.
- Full FIFO with iq_valid in the same cycle as the final rd_next -> level stays 8, ovf_cnt unchanged; rd_start after 3 bytes -> byte 0 of the same frame re-served; rst_n pulse mid-frame -> level=0, byte_valid=0.
